// File: rtl/alu_operand_loader.sv
// alu_operand_loader: builds ALU operands/opcode from switch bytes over load presses and captures the result (option: ALU_LOADER_SYNC_EN)
module alu_operand_loader #(
    parameter int SW_WIDTH   = 8,
    parameter int DATA_WIDTH = 2 * SW_WIDTH,
    parameter int OP_WIDTH   = 4,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic                  load,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_c,
    input  logic [FLAG_WIDTH-1:0] alu_flags,
    output logic [DATA_WIDTH-1:0] result,
    output logic [FLAG_WIDTH-1:0] result_flags,
    output logic                  result_valid,
    output logic [2:0]            state
);
    localparam logic [2:0] S_A_LO = 3'd0;
    localparam logic [2:0] S_A_HI = 3'd1;
    localparam logic [2:0] S_B_LO = 3'd2;
    localparam logic [2:0] S_B_HI = 3'd3;
    localparam logic [2:0] S_OP   = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_SHOW = 3'd6;

    logic                  load_s, clear_s, load_q, ld_edge;
    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;

`ifdef ALU_LOADER_SYNC_EN
    logic [1:0] load_sync_q, clear_sync_q;
    // two-flop synchronizers for the button inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            load_sync_q  <= '0;
            clear_sync_q <= '0;
        end else begin
            load_sync_q  <= {load_sync_q[0], load};
            clear_sync_q <= {clear_sync_q[0], clear};
        end
    end
    assign load_s  = load_sync_q[1];
    assign clear_s = clear_sync_q[1];
`else
    assign load_s  = load;
    assign clear_s = clear;
`endif

    assign ld_edge = load_s & ~load_q;

    // entry sequence: one field per load edge, then a single capture cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (clear_s) begin
            state_d = S_A_LO;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            case (state_q)
                S_A_LO: if (ld_edge) begin
                    a_d[SW_WIDTH-1:0] = sw;
                    state_d = S_A_HI;
                end
                S_A_HI: if (ld_edge) begin
                    a_d[DATA_WIDTH-1:SW_WIDTH] = sw;
                    state_d = S_B_LO;
                end
                S_B_LO: if (ld_edge) begin
                    b_d[SW_WIDTH-1:0] = sw;
                    state_d = S_B_HI;
                end
                S_B_HI: if (ld_edge) begin
                    b_d[DATA_WIDTH-1:SW_WIDTH] = sw;
                    state_d = S_OP;
                end
                S_OP: if (ld_edge) begin
                    op_d = sw[OP_WIDTH-1:0];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    res_d   = alu_c;
                    flags_d = alu_flags;
                    state_d = S_SHOW;
                end
                S_SHOW: state_d = ld_edge ? S_A_LO : S_SHOW;
                default: state_d = S_A_LO;
            endcase
        end
    end

    // state and operand/result registers; edge detector tracks load every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A_LO;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            load_q  <= load_s;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_opcode   = op_q;
    assign result       = res_q;
    assign result_flags = flags_q;
    assign result_valid = (state_q == S_SHOW);
    assign state        = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of the operand loader against a small adder/and ALU stub
module tb_alu_operand_loader;
`ifdef ALU_LOADER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sw = '0;
    logic        load = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] alu_a, alu_b, alu_c, result;
    logic [3:0]  alu_opcode;
    logic [4:0]  alu_flags, result_flags;
    logic        result_valid;
    logic [2:0]  state;
    logic [16:0] sum;
    int          errors = 0;
    int          checks = 0;

    alu_operand_loader dut (
        .clk(clk), .reset(reset), .sw(sw), .load(load), .clear(clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .result(result), .result_flags(result_flags),
        .result_valid(result_valid), .state(state)
    );

    always #5 clk = ~clk;

    assign sum       = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_c     = (alu_opcode == 4'h4) ? sum[15:0] : (alu_a & alu_b);
    assign alu_flags = {4'b0, (alu_opcode == 4'h4) ? sum[16] : 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] v);
        sw = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_a", 32'(alu_a), 0);
        check("rst_b", 32'(alu_b), 0);
        check("rst_op", 32'(alu_opcode), 0);
        check("rst_res", 32'(result), 0);
        check("rst_flags", 32'(result_flags), 0);
        check("rst_valid", 32'(result_valid), 0);
        reset = 1'b0;
        tick();

        press(8'h34);
        check("a_lo", 32'(alu_a), 32'h0034);
        check("st_a_hi", 32'(state), 1);
        press(8'h12);
        press(8'h11);
        press(8'h00);
        check("seq1_a", 32'(alu_a), 32'h1234);
        check("seq1_b", 32'(alu_b), 32'h0011);
        check("seq1_op_state", 32'(state), 4);
        sw = 8'h04;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (LAT) tick();
        check("exec_state", 32'(state), 5);
        check("exec_op", 32'(alu_opcode), 4);
        check("exec_valid", 32'(result_valid), 0);
        tick();
        check("show_state", 32'(state), 6);
        check("show_res", 32'(result), 32'h1245);
        check("show_flags", 32'(result_flags), 0);
        check("show_valid", 32'(result_valid), 1);
        tick();

        press(8'h99);
        check("restart_state", 32'(state), 0);
        check("restart_valid", 32'(result_valid), 0);
        check("restart_res", 32'(result), 32'h1245);
        check("restart_a_kept", 32'(alu_a), 32'h1234);

        sw = 8'hAB;
        load = 1'b1;
        repeat (20) tick();
        check("held_a", 32'(alu_a), 32'h12AB);
        check("held_state", 32'(state), 1);
        load = 1'b0;
        tick();

        pulse_clear();
        check("clr_state", 32'(state), 0);
        check("clr_a", 32'(alu_a), 0);
        check("clr_res_kept", 32'(result), 32'h1245);
        press(8'hFF);
        press(8'hFF);
        press(8'h01);
        press(8'h00);
        press(8'h04);
        check("carry_state", 32'(state), 6);
        check("carry_res", 32'(result), 0);
        check("carry_flag", 32'(result_flags[0]), 1);
        press(8'h00);
        check("carry_restart_state", 32'(state), 0);
        check("carry_restart_res", 32'(result), 0);
        check("carry_restart_valid", 32'(result_valid), 0);

        press(8'h11);
        press(8'h22);
        press(8'h33);
        check("bhi_state", 32'(state), 3);
        sw = 8'h44;
        load = 1'b1;
        clear = 1'b1;
        tick();
        load = 1'b0;
        clear = 1'b0;
        repeat (LAT + 1) tick();
        check("clrld_state", 32'(state), 0);
        check("clrld_a", 32'(alu_a), 0);
        check("clrld_b", 32'(alu_b), 0);
        check("clrld_res_kept", 32'(result), 0);
        check("clrld_flags_kept", 32'(result_flags), 1);

        press(8'h02);
        press(8'h01);
        press(8'h04);
        press(8'h03);
        sw = 8'h04;
        load = 1'b1;
        tick();
        load = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (LAT + 1) tick();
        check("exec_clr_state", 32'(state), 0);
        check("exec_clr_res", 32'(result), 0);
        check("exec_clr_valid", 32'(result_valid), 0);

        press(8'h56);
        press(8'h78);
        press(8'h9A);
        press(8'hBC);
        check("op_state", 32'(state), 4);
        sw = 8'hCD;
        load = 1'b1;
        reset = 1'b1;
        tick();
        check("midrst_state", 32'(state), 0);
        check("midrst_a", 32'(alu_a), 0);
        check("midrst_b", 32'(alu_b), 0);
        check("midrst_res", 32'(result), 0);
        check("midrst_flags", 32'(result_flags), 0);
        reset = 1'b0;
        repeat (LAT + 1) tick();
        check("relload_a", 32'(alu_a), 32'h00CD);
        check("relload_state", 32'(state), 1);
        repeat (5) tick();
        check("relload_once", 32'(state), 1);
        load = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
